// File: rtl/div_ctrl_w_if.sv
// Issue/response handshake and divider-core bus for the RV64M word-divide controller.
interface div_ctrl_w_if #(
  parameter int XLEN = 64,
  parameter int DW   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [XLEN-1:0]   req_src1;
  logic [XLEN-1:0]   req_src2;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              div_valid;
  logic [DW-1:0]     div_a;
  logic [DW-1:0]     div_b;
  logic              div_done;
  logic [2*DW-1:0]   div_c;

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, resp_ready, div_done, div_c,
    input  req_ready, resp_valid, resp_data, div_valid, div_a, div_b
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, resp_ready, div_done, div_c,
    output req_ready, resp_valid, resp_data, div_valid, div_a, div_b
  );
endinterface

// File: rtl/div_ctrl_w.sv
// Execute-stage controller for DIVW/DIVUW/REMW/REMUW: special cases, sign handling
// around an unsigned iterative core, and a sign-extended valid/ready response.
module div_ctrl_w #(
  parameter int XLEN = 64,
  parameter int DW   = 32
) (
  input logic         clk,
  input logic         reset,
  div_ctrl_w_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_RESP, S_DRAIN
  } state_e;

  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext(input logic [DW-1:0] v);
    return {{(XLEN-DW){v[DW-1]}}, v};
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [DW-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic [XLEN-1:0] resp_q, resp_d;

  logic [DW-1:0]   a, b, spec_res, q_fix, r_fix, res_fix;
  logic            is_signed, a_neg, b_neg;
  logic            unused_hi;

  assign unused_hi = ^{bus.req_src1[XLEN-1:DW], bus.req_src2[XLEN-1:DW]};

  always_comb begin
    a         = bus.req_src1[DW-1:0];
    b         = bus.req_src2[DW-1:0];
    is_signed = ~bus.req_op[0];
    a_neg     = is_signed & a[DW-1];
    b_neg     = is_signed & b[DW-1];
    spec_res  = '0;

    // Core works on magnitudes; signs were captured at accept time.
    q_fix = bus.div_c[DW-1:0];
    r_fix = bus.div_c[2*DW-1:DW];
    if (sa_q ^ sb_q) q_fix = -q_fix;
    if (sa_q)        r_fix = -r_fix;
    res_fix = op_q[1] ? r_fix : q_fix;

    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    resp_d  = resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          op_d = bus.req_op;
          sa_d = a_neg;
          sb_d = b_neg;
          if (b == '0) begin
            spec_res = bus.req_op[1] ? a : '1;
            resp_d   = sext(spec_res);
            state_d  = S_RESP;
          end else if (is_signed && a == MIN_NEG && b == '1) begin
            spec_res = bus.req_op[1] ? '0 : MIN_NEG;
            resp_d   = sext(spec_res);
            state_d  = S_RESP;
          end else begin
            div_a_d = a_neg ? -a : a;
            div_b_d = b_neg ? -b : b;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = bus.flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.flush)         state_d = S_DRAIN;
        else if (bus.div_done) state_d = S_FIX;
      end
      S_FIX: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          resp_d  = sext(res_fix);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.flush || bus.resp_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.div_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_a_q <= '0;
      div_b_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_data  = resp_q;
  assign bus.div_valid  = (state_q == S_LAUNCH);
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;

endmodule

// File: tb/tb_div_ctrl_w.sv
// Scoreboard bench for div_ctrl_w with a behavioural fixed-latency divider core.
module tb_div_ctrl_w;

  localparam int unsigned CORE_LAT = 8;

  logic clk;
  logic reset;

  div_ctrl_w_if #(.XLEN(64), .DW(32)) bus ();

  div_ctrl_w #(.XLEN(64), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural unsigned core: busy CORE_LAT cycles after the start pulse.
  logic        core_busy;
  int unsigned core_cnt;
  logic [63:0] core_c;
  int unsigned launches;

  always @(posedge clk) begin
    if (reset) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_c    <= '0;
    end else if (bus.div_valid) begin
      core_busy <= 1'b1;
      core_cnt  <= CORE_LAT;
      core_c    <= (bus.div_b == 0) ? {bus.div_a, 32'hFFFF_FFFF}
                                    : {bus.div_a % bus.div_b, bus.div_a / bus.div_b};
    end else if (core_busy) begin
      if (core_cnt == 1) core_busy <= 1'b0;
      core_cnt <= core_cnt - 1;
    end
  end

  assign bus.div_done = ~core_busy;
  assign bus.div_c    = core_c;

  always @(posedge clk) begin
    if (reset) launches <= 0;
    else if (bus.div_valid) launches <= launches + 1;
  end

  // Response monitor: a flush in the same cycle means the result was not taken.
  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready && !bus.flush) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_resp: got %h, expected no response", bus.resp_data);
      end else begin
        chk("resp_data", bus.resp_data, sb_q.pop_front());
      end
    end
  end

  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (!reset && bus.div_valid) chk("div_valid_one_cycle", {63'd0, prev_dv}, 64'd0);
    prev_dv = bus.div_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2);
    int unsigned n = 0;
    while (!bus.req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = s1;
    bus.req_src2  = s2;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2,
                      input logic [63:0] exp);
    sb_q.push_back(exp);
    issue(op, s1, s2);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (!bus.req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.req_ready) chk("idle_timeout", {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic wait_resp_valid();
    int unsigned n = 0;
    while (!bus.resp_valid && n < 200) begin
      tick();
      n++;
    end
    if (!bus.resp_valid) chk("resp_valid_timeout", {63'd0, bus.resp_valid}, 64'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6] = '{
    '{2'd1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000},
    '{2'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000},
    '{2'd0, 64'h0000_0000_FFFF_FFEC, 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_0000_0006},
    '{2'd2, 64'h0000_0000_FFFF_FFEC, 64'h0000_0000_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE},
    '{2'd1, 64'h1234_5678_0000_0064, 64'hFFFF_0000_0000_0007, 64'h0000_0000_0000_000E},
    '{2'd0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    int unsigned l0;
    int unsigned drain;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_src1   = '0;
    bus.req_src2   = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) tick();

    chk("rst_req_ready",  {63'd0, bus.req_ready},  64'd1);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_data",  bus.resp_data,           64'd0);
    chk("rst_div_valid",  {63'd0, bus.div_valid},  64'd0);
    chk("rst_div_a",      {32'd0, bus.div_a},      64'd0);
    chk("rst_div_b",      {32'd0, bus.div_b},      64'd0);
    reset = 1'b0;
    tick();

    // DIVW 20 / -3, with launch operands, stability and latency
    send(2'd0, 64'd20, 64'h0000_0000_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("launch_div_valid", {63'd0, bus.div_valid}, 64'd1);
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      chk("div_a_stable", {32'd0, bus.div_a}, 64'd20);
      chk("div_b_stable", {32'd0, bus.div_b}, 64'd3);
      tick();
      lat++;
    end
    chk("latency_normal", 64'(lat), 64'(CORE_LAT + 3));
    wait_idle();

    send(2'd2, 64'd20, 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_0000_0002);
    send(2'd1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();

    // Special cases: one-cycle latency, no core launch
    l0 = launches;
    send(2'd3, 64'd7, 64'd0, 64'h0000_0000_0000_0007);
    chk("remuw_by0_lat1", {63'd0, bus.resp_valid}, 64'd1);
    wait_idle();
    send(2'd0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    chk("divw_ovf_lat1", {63'd0, bus.resp_valid}, 64'd1);
    send(2'd2, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0000);
    send(2'd0, 64'd5, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    tick();
    chk("special_no_launch", 64'(launches), 64'(l0));

    send(2'd2, 64'hDEAD_BEEF_FFFF_FFF9, 64'hDEAD_BEEF_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 6; i++) send(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].exp);
    wait_idle();

    // Flush 5 cycles after launch: no response, held off until the core finishes
    issue(2'd0, 64'd100, 64'd7);
    repeat (5) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("drain_req_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("drain_core_busy", {63'd0, bus.div_done},  64'd0);
    drain = 0;
    while (!bus.req_ready && drain < 100) begin
      chk("drain_no_resp", {63'd0, bus.resp_valid}, 64'd0);
      tick();
      drain++;
    end
    chk("drain_cycles", 64'(drain), 64'd4);
    send(2'd0, 64'd9, 64'd3, 64'd3);
    wait_idle();

    // Backpressure: result held stable, no new accept
    bus.resp_ready = 1'b0;
    send(2'd1, 64'd100, 64'd7, 64'h0000_0000_0000_000E);
    wait_resp_valid();
    for (int i = 0; i < 10; i++) begin
      chk("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      chk("bp_resp_data",  bus.resp_data,           64'h0000_0000_0000_000E);
      chk("bp_req_ready",  {63'd0, bus.req_ready},  64'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_back_idle", {63'd0, bus.req_ready}, 64'd1);

    // Flush wins over resp_ready in RESP
    bus.resp_ready = 1'b0;
    issue(2'd0, 64'd20, 64'h0000_0000_FFFF_FFFD);
    wait_resp_valid();
    bus.flush      = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("flush_resp_idle",  {63'd0, bus.req_ready},  64'd1);

    // Flush in IDLE blocks acceptance
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_src1  = 64'd50;
    bus.req_src2  = 64'd5;
    bus.flush     = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_idle_ready",  {63'd0, bus.req_ready}, 64'd1);
    chk("flush_idle_launch", {63'd0, bus.div_valid}, 64'd0);

    // Reset while waiting on the core
    issue(2'd0, 64'd20, 64'h0000_0000_FFFF_FFFD);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rstw_req_ready",  {63'd0, bus.req_ready},  64'd1);
    chk("rstw_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rstw_resp_data",  bus.resp_data,           64'd0);
    chk("rstw_div_valid",  {63'd0, bus.div_valid},  64'd0);
    chk("rstw_div_a",      {32'd0, bus.div_a},      64'd0);
    chk("rstw_div_b",      {32'd0, bus.div_b},      64'd0);
    reset = 1'b0;
    tick();
    send(2'd1, 64'd9, 64'd3, 64'd3);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
